// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback-select, big-endian load-lane extraction and a retire counter.
// Define MEM_WB_SUBWORD_LOAD_EN to enable lb/lbu/lh/lhu extraction; otherwise every load returns the raw word.
module mem_wb_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [2:0]       LoadTypeM,
  input  logic [4:0]       WriteRegM,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] ReadDataM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic             ValidW,
  output logic             RegWriteW,
  output logic [4:0]       WriteRegW,
  output logic [WIDTH-1:0] ResultW,
  output logic [CNT_W-1:0] RetiredW
);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_e;

  logic             valid_q,    valid_d;
  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic [4:0]       writereg_q, writereg_d;
  logic [WIDTH-1:0] aluout_q,   aluout_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [CNT_W-1:0] retired_q,  retired_d;
  logic             retire;
`ifdef MEM_WB_SUBWORD_LOAD_EN
  load_e            loadtype_q, loadtype_d;
`else
  logic             unused_loadtype;
  assign unused_loadtype = ^LoadTypeM;
`endif

  // An instruction retires when it leaves WB: valid, not held, not squashed.
  assign retire = valid_q & ~StallW & ~FlushW;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the ifs can infer a latch.
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    writereg_d = writereg_q;
    aluout_d   = aluout_q;
    readdata_d = readdata_q;
`ifdef MEM_WB_SUBWORD_LOAD_EN
    loadtype_d = loadtype_q;
`endif
    retired_d  = retired_q + CNT_W'(retire);
    if (FlushW) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!StallW) begin
      valid_d    = ValidM;
      regwrite_d = RegWriteM;
      memtoreg_d = MemtoRegM;
      writereg_d = WriteRegM;
      aluout_d   = ALUOutM;
      readdata_d = ReadDataM;
`ifdef MEM_WB_SUBWORD_LOAD_EN
      loadtype_d = load_e'(LoadTypeM);
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      writereg_q <= '0;
      aluout_q   <= '0;
      readdata_q <= '0;
`ifdef MEM_WB_SUBWORD_LOAD_EN
      loadtype_q <= LD_W;
`endif
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      writereg_q <= writereg_d;
      aluout_q   <= aluout_d;
      readdata_q <= readdata_d;
`ifdef MEM_WB_SUBWORD_LOAD_EN
      loadtype_q <= loadtype_d;
`endif
      retired_q  <= retired_d;
    end
  end

  logic [WIDTH-1:0] load_data;

`ifdef MEM_WB_SUBWORD_LOAD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian lanes: byte 0 lives in [31:24], half 0 in [31:16].
  always_comb begin
    byte_sel = readdata_q[31:24];
    case (aluout_q[1:0])
      2'd1:    byte_sel = readdata_q[23:16];
      2'd2:    byte_sel = readdata_q[15:8];
      2'd3:    byte_sel = readdata_q[7:0];
      default: byte_sel = readdata_q[31:24];
    endcase
    half_sel = aluout_q[1] ? readdata_q[15:0] : readdata_q[31:16];

    load_data = readdata_q;
    case (loadtype_q)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'd0, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'd0, half_sel};
      default: load_data = readdata_q;
    endcase
  end
`else
  assign load_data = readdata_q;
`endif

  assign ValidW    = valid_q;
  assign RegWriteW = valid_q & regwrite_q & (writereg_q != 5'd0);
  assign WriteRegW = writereg_q;
  assign ResultW   = memtoreg_q ? load_data : aluout_q;
  assign RetiredW  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected W-stage state, a negedge monitor pops and compares.
// A second instance with a 4-bit counter exercises counter wrap on the same stimulus.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, MemtoRegM;
  logic [2:0]  LoadTypeM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM;
  logic        StallW, FlushW;
  logic        ValidW, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [31:0] RetiredW;
  logic        ValidW4, RegWriteW4;
  logic [4:0]  WriteRegW4;
  logic [31:0] ResultW4;
  logic [3:0]  RetiredW4;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .StallW(StallW), .FlushW(FlushW), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .ResultW(ResultW), .RetiredW(RetiredW)
  );

  mem_wb_stage #(.WIDTH(32), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .StallW(StallW), .FlushW(FlushW), .ValidW(ValidW4), .RegWriteW(RegWriteW4),
    .WriteRegW(WriteRegW4), .ResultW(ResultW4), .RetiredW(RetiredW4)
  );

`ifdef MEM_WB_SUBWORD_LOAD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  localparam logic [2:0]  LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011, LHU = 3'b100;
  localparam logic [31:0] RD = 32'h80FF_7F01;

  typedef struct {
    string       name;
    logic        valid;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] result;
    logic [31:0] retired;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.name, ".ValidW"},    32'(ValidW),    32'(e.valid));
      check({e.name, ".RegWriteW"}, 32'(RegWriteW), 32'(e.regwrite));
      if (e.chk_data) begin
        check({e.name, ".WriteRegW"}, 32'(WriteRegW), 32'(e.writereg));
        check({e.name, ".ResultW"},   ResultW,        e.result);
      end
      check({e.name, ".RetiredW"},   RetiredW,        e.retired);
      check({e.name, ".RetiredW4"},  32'(RetiredW4),  {28'd0, e.retired[3:0]});
    end
  end

  // Drive one cycle of inputs, then queue the W-stage state expected after the next posedge.
  task automatic cyc(input string name, input logic rst, input logic v, input logic rw, input logic mtr,
                     input logic [2:0] lt, input logic [4:0] wr, input logic [31:0] alu,
                     input logic st, input logic fl,
                     input logic ev, input logic erw, input logic [4:0] ewr, input logic [31:0] eres,
                     input logic [31:0] eret, input bit edat);
    exp_t x;
    reset = rst; ValidM = v; RegWriteM = rw; MemtoRegM = mtr; LoadTypeM = lt;
    WriteRegM = wr; ALUOutM = alu; ReadDataM = RD; StallW = st; FlushW = fl;
    @(posedge clk);
    x.name = name; x.valid = ev; x.regwrite = erw; x.writereg = ewr;
    x.result = eres; x.retired = eret; x.chk_data = edat;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    // reset held two cycles, then three idle cycles
    for (int i = 0; i < 2; i++) cyc("reset", 1, 0,0,0, LW, 0, 0, 0,0,  0,0,0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("idle",  0, 0,0,0, LW, 0, 0, 0,0,  0,0,0, 0, 0, 1);

    cyc("alu",      0, 1,1,0, LW,  5, 32'h0000_1234, 0,0,  1,1,5,  32'h0000_1234, 0, 1);
    cyc("idle1",    0, 0,0,0, LW,  0, 0,             0,0,  0,0,0,  0,             1, 1);

    cyc("lb_a1",    0, 1,1,1, LB,  8, 32'h1000_0001, 0,0,  1,1,8,  SUB ? 32'hFFFF_FFFF : RD, 1, 1);
    cyc("lbu_a1",   0, 1,1,1, LBU, 9, 32'h1000_0001, 0,0,  1,1,9,  SUB ? 32'h0000_00FF : RD, 2, 1);
    cyc("lb_a3",    0, 1,1,1, LB, 10, 32'h1000_0003, 0,0,  1,1,10, SUB ? 32'h0000_0001 : RD, 3, 1);
    cyc("lh_a0",    0, 1,1,1, LH, 11, 32'h1000_0000, 0,0,  1,1,11, SUB ? 32'hFFFF_80FF : RD, 4, 1);
    cyc("lhu_a2",   0, 1,1,1, LHU,12, 32'h1000_0002, 0,0,  1,1,12, SUB ? 32'h0000_7F01 : RD, 5, 1);
    cyc("lw_a1",    0, 1,1,1, LW, 13, 32'h1000_0001, 0,0,  1,1,13, RD,                       6, 1);
    cyc("lt7_a1",   0, 1,1,1, 3'b111,14, 32'h1000_0001, 0,0, 1,1,14, RD,                     7, 1);
    cyc("lhu_a3",   0, 1,1,1, LHU,15, 32'h1000_0003, 0,0,  1,1,15, SUB ? 32'h0000_7F01 : RD, 8, 1);
    cyc("lb_a0",    0, 1,1,1, LB, 16, 32'h1000_0000, 0,0,  1,1,16, SUB ? 32'hFFFF_FF80 : RD, 9, 1);
    cyc("lbu_a2",   0, 1,1,1, LBU,17, 32'h1000_0002, 0,0,  1,1,17, SUB ? 32'h0000_007F : RD, 10, 1);

    // write to $0 is suppressed but still retires
    cyc("wr_r0",    0, 1,1,0, LW,  0, 32'h0000_DEAD, 0,0,  1,0,0,  32'h0000_DEAD, 11, 1);
    cyc("alu_r7",   0, 1,1,0, LW,  7, 32'h0000_CAFE, 0,0,  1,1,7,  32'h0000_CAFE, 12, 1);

    // stall three cycles with different inputs present: outputs and counter frozen
    for (int i = 0; i < 3; i++)
      cyc("stall",  0, 1,1,0, LW,  3, 32'h0000_5555, 1,0,  1,1,7,  32'h0000_CAFE, 12, 1);
    cyc("stall_flush", 0, 1,1,0, LW, 3, 32'h0000_5555, 1,1, 0,0,0, 0, 12, 0);
    cyc("idle2",    0, 0,0,0, LW,  0, 0,             0,0,  0,0,0,  0,             12, 1);

    // 16 back-to-back retirements of non-writing instructions; 4-bit counter passes 15 -> 0
    for (int i = 0; i < 16; i++)
      cyc("wrap",   0, 1,0,0, LW,  2, 32'(i),        0,0,  1,0,2,  32'(i),        32'(12 + i), 1);
    cyc("idle3",    0, 0,0,0, LW,  0, 0,             0,0,  0,0,0,  0,             28, 1);

    // valid instruction in flight, then reset together with stall and flush
    cyc("pre_rst",  0, 1,1,0, LW,  4, 32'h0000_0042, 0,0,  1,1,4,  32'h0000_0042, 28, 1);
    cyc("rst_sf",   1, 1,1,0, LW,  4, 32'h0000_0077, 1,1,  0,0,0,  0,             0,  1);
    cyc("post_rst", 0, 0,0,0, LW,  0, 0,             0,0,  0,0,0,  0,             0,  1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
